// File: rtl/vga_pkg.sv
// Shared VGA definitions: 640x480 timing constants, 24-bit pixel packing and capture states.
package vga_pkg;

  localparam int HACTIVE = 640;
  localparam int HFP     = 16;
  localparam int HSYN    = 96;
  localparam int HBP     = 48;
  localparam int HMAX    = HACTIVE + HFP + HSYN + HBP;
  localparam int VACTIVE = 480;
  localparam int VFP     = 10;
  localparam int VSYN    = 2;
  localparam int VBP     = 33;
  localparam int VMAX    = VACTIVE + VFP + VSYN + VBP;

  typedef struct packed {
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } pix24_t;

  function automatic pix24_t pack_pix(input logic [7:0] r, input logic [7:0] g,
                                      input logic [7:0] b);
    pix24_t p;
    p.r = r;
    p.g = g;
    p.b = b;
    return p;
  endfunction

  typedef enum logic [2:0] {IDLE, ARM, SYNC, CAPTURE, FINISH} cap_state_t;

endpackage

// File: rtl/vga_strobe_edge.sv
// Rise/fall detector for one video signal, sampled only on pix_en cycles.
// Edges are combinational against the previous qualified sample.
module vga_strobe_edge (
  input  logic clk,
  input  logic rst,
  input  logic pix_en_i,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else if (pix_en_i) begin
      prev_q <= sig_i;
    end
  end

  assign rise_o = pix_en_i &  sig_i & ~prev_q;
  assign fall_o = pix_en_i & ~sig_i &  prev_q;

endmodule

// File: rtl/vga_frame_capture.sv
// Captures one active VGA frame into linear image memory as packed {b,g,r} words.
// Writes are registered one clk after the pix_en sample; line_base is a running sum, no multiplier.
module vga_frame_capture
  import vga_pkg::*;
#(
  parameter int HACTIVE = vga_pkg::HACTIVE,
  parameter int VACTIVE = vga_pkg::VACTIVE,
  parameter int AW      = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          blank_b,
  input  logic [7:0]    r,
  input  logic [7:0]    g,
  input  logic [7:0]    b,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [23:0]   mem_wdata
);

  localparam int XW = $clog2(HACTIVE + 1);
  localparam int YW = $clog2(VACTIVE + 1);
  localparam logic [XW-1:0] XFULL = XW'(HACTIVE);
  localparam logic [YW-1:0] YLAST = YW'(VACTIVE - 1);
  localparam logic [AW-1:0] HSTEP = AW'(HACTIVE);

  logic hs_rise_unused, hs_fall_unused;
  logic vs_rise_unused, vs_fall;
  logic bl_rise, bl_fall;

  vga_strobe_edge u_hs_edge (
    .clk(clk), .rst(rst), .pix_en_i(pix_en), .sig_i(hsync),
    .rise_o(hs_rise_unused), .fall_o(hs_fall_unused)
  );
  vga_strobe_edge u_vs_edge (
    .clk(clk), .rst(rst), .pix_en_i(pix_en), .sig_i(vsync),
    .rise_o(vs_rise_unused), .fall_o(vs_fall)
  );
  vga_strobe_edge u_bl_edge (
    .clk(clk), .rst(rst), .pix_en_i(pix_en), .sig_i(blank_b),
    .rise_o(bl_rise), .fall_o(bl_fall)
  );

  cap_state_t    state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [AW-1:0] base_q, base_d;
  logic          sticky_q, sticky_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [23:0]   wdata_q, wdata_d;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    base_d   = base_q;
    sticky_d = sticky_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = ARM;
          busy_d   = 1'b1;
          x_d      = '0;
          y_d      = '0;
          base_d   = '0;
          sticky_d = 1'b0;
        end
      end
      ARM: begin
        if (vs_fall) state_d = SYNC;
      end
      SYNC: begin
        if (bl_rise) begin
          state_d = CAPTURE;
          we_d    = 1'b1;
          addr_d  = base_q;
          wdata_d = pack_pix(r, g, b);
          x_d     = XW'(1);
        end
      end
      CAPTURE: begin
        if (vs_fall) begin
          state_d = FINISH;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (pix_en && blank_b) begin
          if (x_q < XFULL) begin
            we_d    = 1'b1;
            addr_d  = base_q + AW'(x_q);
            wdata_d = pack_pix(r, g, b);
            x_d     = x_q + XW'(1);
          end else begin
            // x saturates, so an over-long line is only visible here
            sticky_d = 1'b1;
          end
        end else if (bl_fall) begin
          base_d = base_q + HSTEP;
          x_d    = '0;
          y_d    = y_q + YW'(1);
          if (x_q != XFULL) sticky_d = 1'b1;
          if (y_q == YLAST) begin
            state_d = FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            err_d   = sticky_q | (x_q != XFULL);
          end
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      base_q   <= '0;
      sticky_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      base_q   <= base_d;
      sticky_q <= sticky_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_vga_frame_capture.sv
// Bench for vga_frame_capture with a reduced 8x4 frame; writes are scoreboarded against a pattern model.
module tb_vga_frame_capture;

  localparam int HACT = 8;
  localparam int VACT = 4;
  localparam int AW   = 24;

  logic          clk = 1'b0;
  logic          rst, pix_en, hsync, vsync, blank_b, start;
  logic [7:0]    r, g, b;
  logic          busy, done, err, mem_we;
  logic [AW-1:0] mem_addr;
  logic [23:0]   mem_wdata;

  vga_frame_capture #(.HACTIVE(HACT), .VACTIVE(VACT), .AW(AW)) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
    .blank_b(blank_b), .r(r), .g(g), .b(b), .start(start),
    .busy(busy), .done(done), .err(err), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] addr;
    logic [23:0] data;
  } wr_t;

  typedef struct packed {
    logic [3:0][7:0] lens;
    logic [7:0]      nlines;
    logic [7:0]      restart_line;
    logic [15:0]     exp_writes;
    logic            exp_err;
  } vec_t;

  int   tests = 0, fails = 0;
  int   cyc = 0;
  int   writes = 0, done_cnt = 0, last_we_cyc = 0, last_done_cyc = 0;
  logic last_err = 1'b0;
  logic [23:0] seen_x1y1;
  logic cap = 1'b0;
  wr_t  exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] pat(input int x, input int y);
    logic [7:0] xr, yg;
    xr = 8'(x);
    yg = 8'(y);
    return {xr ^ yg, yg, xr};
  endfunction

  function automatic vec_t mkv(input int l0, l1, l2, l3, n, rl, w, input logic e);
    vec_t v;
    v.lens[0] = 8'(l0); v.lens[1] = 8'(l1); v.lens[2] = 8'(l2); v.lens[3] = 8'(l3);
    v.nlines = 8'(n); v.restart_line = 8'(rl); v.exp_writes = 16'(w); v.exp_err = e;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic observe();
    wr_t e;
    if (mem_we === 1'b1) begin
      writes++;
      last_we_cyc = cyc;
      if (mem_addr == 24'(HACT + 1)) seen_x1y1 = mem_wdata;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e.addr));
        check("wr_data", 32'(mem_wdata), 32'(e.data));
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      last_err = err;
      last_done_cyc = cyc;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      @(negedge clk); observe();
    end
  endtask

  // One pixel slot = two clks; start/rst ride the strobe clk only.
  task automatic px(input logic hs, input logic vs, input logic bl, input logic [7:0] rr,
                    input logic [7:0] gg, input logic [7:0] bb, input logic st, input logic rs);
    hsync = hs; vsync = vs; blank_b = bl; r = rr; g = gg; b = bb;
    pix_en = 1'b1; start = st; rst = rs;
    @(posedge clk); #1;
    pix_en = 1'b0; start = 1'b0; rst = 1'b0;
    @(negedge clk); observe();
    idle(1);
  endtask

  task automatic drive_line(input int len, input int y, input int start_at, input int rst_at);
    logic [23:0] p;
    wr_t e;
    for (int i = 0; i < len; i++) begin
      if (i == rst_at) cap = 1'b0;
      p = pat(i, y);
      if (cap && i < HACT) begin
        e.addr = 24'(y * HACT + i);
        e.data = p;
        exp_q.push_back(e);
      end
      px(1'b1, 1'b1, 1'b1, p[7:0], p[15:8], p[23:16], i == start_at, i == rst_at);
    end
    for (int i = 0; i < 4; i++) px(!(i == 1 || i == 2), 1'b1, 1'b0, 8'h0, 8'h0, 8'h0, 1'b0, 1'b0);
  endtask

  task automatic vsync_porch();
    for (int i = 0; i < 4; i++) px(1'b1, i >= 2, 1'b0, 8'h0, 8'h0, 8'h0, 1'b0, 1'b0);
  endtask

  task automatic drive_frame(input vec_t v);
    cap = 1'b1;
    vsync_porch();
    for (int l = 0; l < int'(v.nlines); l++)
      drive_line(int'(v.lens[l]), l, (l == int'(v.restart_line)) ? 2 : -1, -1);
    if (int'(v.nlines) < VACT) vsync_porch();
    for (int i = 0; i < 3; i++) px(1'b1, 1'b1, 1'b0, 8'h0, 8'h0, 8'h0, 1'b0, 1'b0);
    cap = 1'b0;
  endtask

  vec_t vecs[5];

  initial begin
    int w0, d0;
    vecs[0] = mkv(8, 8,  8, 8, 4, 255, 32, 1'b0);  // clean frame
    vecs[1] = mkv(8, 10, 8, 8, 4, 255, 32, 1'b1);  // long line truncated
    vecs[2] = mkv(8, 8,  5, 8, 4, 255, 29, 1'b1);  // short line
    vecs[3] = mkv(8, 8,  8, 8, 2, 255, 16, 1'b1);  // early vsync abort
    vecs[4] = mkv(8, 8,  8, 8, 4, 1,   32, 1'b0);  // start while busy ignored

    rst = 1'b1; pix_en = 1'b0; hsync = 1'b1; vsync = 1'b1; blank_b = 1'b0;
    start = 1'b0; r = '0; g = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_we", 32'(mem_we), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_wdata", 32'(mem_wdata), 0);
    rst = 1'b0;

    // start with no pixel strobes: armed forever, no writes, reset clears it
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk); observe();
    check("busy_after_start", 32'(busy), 1);
    idle(20);
    check("busy_no_pix", 32'(busy), 1);
    check("writes_no_pix", 32'(writes), 0);
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk); observe();
    check("busy_after_rst", 32'(busy), 0);
    check("we_after_rst", 32'(mem_we), 0);

    for (int k = 0; k < 5; k++) begin
      w0 = writes; d0 = done_cnt; seen_x1y1 = '0;
      cap = 1'b0;
      drive_line(HACT, 0, 1, -1);   // start lands mid-frame
      drive_line(HACT, 1, -1, -1);
      check($sformatf("v%0d_busy_armed", k), 32'(busy), 1);
      check($sformatf("v%0d_writes_before_frame", k), 32'(writes - w0), 0);
      drive_frame(vecs[k]);
      idle(4);
      check($sformatf("v%0d_done_count", k), 32'(done_cnt - d0), 1);
      check($sformatf("v%0d_err", k), 32'(last_err), 32'(vecs[k].exp_err));
      check($sformatf("v%0d_writes", k), 32'(writes - w0), 32'(vecs[k].exp_writes));
      check($sformatf("v%0d_leftover", k), 32'(exp_q.size()), 0);
      check($sformatf("v%0d_busy_end", k), 32'(busy), 0);
      if (!vecs[k].exp_err)
        check($sformatf("v%0d_done_gap", k), 32'(last_done_cyc - last_we_cyc), 2);
      if (k == 0) check("v0_data_x1y1", 32'(seen_x1y1), 32'(pat(1, 1)));
      exp_q.delete();
    end

    // reset in the middle of line 2
    d0 = done_cnt;
    cap = 1'b0;
    drive_line(HACT, 0, 1, -1);
    cap = 1'b1;
    vsync_porch();
    drive_line(HACT, 0, -1, -1);
    drive_line(HACT, 1, -1, -1);
    drive_line(HACT, 2, -1, 3);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_err", 32'(err), 0);
    check("rst_mid_we", 32'(mem_we), 0);
    check("rst_mid_addr", 32'(mem_addr), 0);
    check("rst_mid_wdata", 32'(mem_wdata), 0);
    drive_line(HACT, 3, -1, -1);
    idle(6);
    check("rst_mid_no_done", 32'(done_cnt - d0), 0);
    check("rst_mid_leftover", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_frame_capture.md
Name: vga_frame_capture

Overview:
- Sink end of the team's 640x480 VGA pixel interface: consumes hsync/vsync/blank_b/r/g/b as produced by the display controller and recovers pixel coordinates.
- Writes one complete active frame into the image memory, in the same 24-bit pixel packing and linear addressing the display path reads back.
- Used for loopback self-test of the video path and for loading frames from an external VGA-timed source.

Parameters:
- HACTIVE, 640, active pixels per line
- VACTIVE, 480, active lines per frame
- AW, 24, memory address width

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- pix_en  in  1  pixel strobe, one clk wide; video inputs valid only when high (vgaclk = clk/2)
- hsync  in  1  horizontal sync, active low
- vsync  in  1  vertical sync, active low
- blank_b  in  1  high inside active display area
- r, g, b  in  8 each  pixel colour
- start  in  1  one-cycle pulse; arms capture of the next full frame
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of capture
- err  out  1  valid with done; 1 = frame aborted or a line length was wrong
- mem_we  out  1  memory write enable
- mem_addr  out  AW  write address
- mem_wdata  out  24  {b,g,r}: r in [7:0], g in [15:8], b in [23:16]

Behaviour:
- Reset values: busy=0, done=0, err=0, mem_we=0, mem_addr=0, mem_wdata=0, state IDLE, all counters 0.
- All sampling and edge detection happen only on cycles with pix_en=1. Edges are computed against the previous pix_en sample.
- States:
  - IDLE: start -> ARM, busy=1. start is ignored in any other state.
  - ARM: vsync falling edge -> SYNC.
  - SYNC: first blank_b rising edge -> CAPTURE. That pixel is pixel (0,0) and is written.
  - CAPTURE: see below.
  - FINISH: one cycle; done=1, busy=0 -> IDLE.
- CAPTURE, each pix_en with blank_b=1:
  - If x < HACTIVE: write with mem_addr = line_base + x and mem_wdata = {b,g,r}.
  - x increments, saturating at HACTIVE. Pixels with x >= HACTIVE are not written.
- CAPTURE, line end (blank_b falling edge):
  - If x != HACTIVE, set the sticky err flag.
  - line_base += HACTIVE, x = 0, y += 1.
  - If y reaches VACTIVE -> FINISH with done=1 and err = sticky flag.
- Abort: a vsync falling edge in CAPTURE with y < VACTIVE -> FINISH with err=1. No further writes occur.
- Address arithmetic: no multiplier; line_base is an AW-bit running sum. The maximum address is 307199, which fits in AW.
- Latency: mem_we/mem_addr/mem_wdata are registered and assert 1 clk after the pix_en sample. mem_we is high exactly 1 clk per written pixel.
- A full frame produces exactly HACTIVE*VACTIVE = 307200 writes, addresses 0..307199 ascending.
- Reset mid-capture returns to IDLE with no done pulse. The write in flight is dropped; mem_we is 0 the cycle after rst.
- Sync polarity and porch widths are not checked. Only blank_b and the sync falling edges are used.

Decomposition:
- Shared package vga_pkg:
  - timing constants HACTIVE, HFP, HSYN, HBP, HMAX, VACTIVE, VFP, VSYN, VBP, VMAX (also used by the display controller)
  - pixel packing helper/typedef pix24_t
  - capture state enum {IDLE, ARM, SYNC, CAPTURE, FINISH}
- Sub-module vga_strobe_edge: detects rise/fall of one signal qualified by pix_en. Instantiated three times (hsync, vsync, blank_b).

Test Plan:
- Loopback from the team's vgaController/videoGen with an x^y pattern, start pulsed mid-frame:
  - capture begins at the next frame
  - 307200 writes, first addr 0, last 307199
  - data at addr 641 = pattern(1,1)
  - done with err=0, 1 clk after the last write cycle + FINISH
- start with pix_en never asserted: busy stays 1, no writes. Then reset: busy=0, mem_we=0 next clk.
- One line with 648 active pixels: 640 writes for that line. The next line starts at line_base + 640. done err=1.
- One line with 632 active pixels: the next line starts at line_base + 640. done err=1.
- Second vsync falling edge after 100 lines: 64000 writes total, done err=1, back to IDLE. A new start then captures cleanly with err=0.
- start pulsed again while busy: ignored, one done only. rst asserted during line 200: no done, IDLE, outputs at reset values.
